// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
//   Constants and types shared between the 2-way cache and its fill logic.
//
//   ADDR_W / DATA_W     byte-address and word widths
//   WORDS_PER_BLOCK     words fetched per miss (power of 2)
//   OFFSET_W            block-offset bits, log2(block size in bytes)
//   CNT_W               fill counter width; one extra bit so that the
//                       value WORDS_PER_BLOCK itself can be held
//   fill_state_t        fill FSM states {IDLE, FILL}
//   word_addr()         byte address of word 'idx' inside a block
// -----------------------------------------------------------------------------
package cache_pkg;

  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int BYTES_PER_WORD  = DATA_W / 8;
  localparam int OFFSET_W        = $clog2(WORDS_PER_BLOCK * BYTES_PER_WORD);
  localparam int WORD_SHIFT      = $clog2(BYTES_PER_WORD);
  localparam int CNT_W           = $clog2(WORDS_PER_BLOCK) + 1;
  localparam int MISS_COUNT_W    = 16;

  // Clears the block-offset bits of a byte address.
  localparam logic [ADDR_W-1:0] BLOCK_MASK =
    {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_t;

  // Word offsets stay below 2^OFFSET_W, so adding them to a block-aligned
  // base never carries into the tag bits.
  function automatic logic [ADDR_W-1:0] word_addr(
    input logic [ADDR_W-1:0] base,
    input logic [CNT_W-1:0]  idx
  );
    return base + (ADDR_W'(idx) << WORD_SHIFT);
  endfunction

endpackage : cache_pkg

// File: rtl/fill_counter.sv
// -----------------------------------------------------------------------------
// fill_counter
//   Synchronous up-counter used to track words issued to / received from
//   main memory during a cache fill.
//
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset (count -> 0)
//   clr    in   synchronous clear, takes priority over inc
//   inc    in   increment by one this cycle
//   count  out  current count
// -----------------------------------------------------------------------------
module fill_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule : fill_counter

// File: rtl/cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// cache_fill_fsm
//   Miss handler sitting in front of the 2-way cache data/meta arrays. On a
//   miss it fetches the whole block (WORDS_PER_BLOCK words) from pipelined
//   main memory, streams each returned word into the data array and pulses
//   the tag/valid/LRU update together with the last word. fsm_busy stalls
//   the pipeline for the duration of the fill.
//
//   Optional feature: define CACHE_FILL_MISS_COUNTER_EN to add the
//   miss_count output (completed fills, saturating, cleared by rst).
//
//   Ports
//   clk                in   clock, rising edge
//   rst                in   synchronous active-high reset
//   miss_detected      in   cache miss this cycle
//   miss_address       in   byte address of the missing access
//   memory_data        in   word returned by memory
//   memory_data_valid  in   memory_data valid this cycle
//   fsm_busy           out  fill in progress (registered)
//   mem_read_en        out  issue a memory read this cycle
//   memory_address     out  address of the issued read
//   write_data_array   out  write fill_data into the data array this cycle
//   fill_address       out  data-array write address (set/word select)
//   fill_data          out  word to write (memory_data, passed through)
//   write_tag_array    out  one-cycle tag/valid/LRU update pulse
//   miss_count         out  completed fills (CACHE_FILL_MISS_COUNTER_EN only)
//   state_dbg          out  current FSM state, for observation only
//
//   Memory interface: there is no ready/backpressure in either direction.
//   A cycle with mem_read_en=1 is one accepted request; memory must accept
//   it that cycle. A cycle with memory_data_valid=1 delivers one word, in
//   request order; the FSM always consumes it while in FILL and ignores it
//   in IDLE.
// -----------------------------------------------------------------------------
module cache_fill_fsm
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic [DATA_W-1:0] memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [ADDR_W-1:0] fill_address,
  output logic [DATA_W-1:0] fill_data,
  output logic              write_tag_array,
`ifdef CACHE_FILL_MISS_COUNTER_EN
  output logic [MISS_COUNT_W-1:0] miss_count,
`endif
  output fill_state_t       state_dbg
);

  fill_state_t       state;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  recv_cnt;

  logic issue_active;
  logic recv_fire;
  logic last_word;
  logic cnt_clr;

  // ---------------------------------------------------------------------------
  // Issue and receive run concurrently in FILL: requests go out back to back
  // until all words are requested, while returning words are written as they
  // arrive (gaps allowed). The fill ends on the last received word, not on
  // the last request.
  // ---------------------------------------------------------------------------
  always_comb begin
    issue_active = (state == FILL) && (issue_cnt < CNT_FULL);
    recv_fire    = (state == FILL) && memory_data_valid;
    last_word    = recv_fire && (recv_cnt == CNT_LAST);
    // Counters are held at zero in IDLE, so a fill that starts right after
    // another one, or after an abort, always begins from word 0.
    cnt_clr      = (state == IDLE) || last_word;
  end

  fill_counter #(
    .W (CNT_W)
  ) u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (issue_active),
    .count (issue_cnt)
  );

  fill_counter #(
    .W (CNT_W)
  ) u_recv_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (recv_fire),
    .count (recv_cnt)
  );

  // ---------------------------------------------------------------------------
  // Control FSM. A miss is only accepted from IDLE; a miss raised while busy,
  // including in the cycle of the final word, is dropped and the cache
  // re-raises it once fsm_busy falls.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      base     <= '0;
      fsm_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            base     <= miss_address & BLOCK_MASK;
            state    <= FILL;
            fsm_busy <= 1'b1;
          end
        end
        FILL: begin
          if (last_word) begin
            state    <= IDLE;
            fsm_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          fsm_busy <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode. The data path is forwarded in the same cycle the word
  // arrives; addresses and data are forced to zero when their strobe is low
  // so that nothing stale is presented to the arrays (and so that every
  // output reads zero under reset).
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_read_en      = issue_active;
    memory_address   = issue_active ? word_addr(base, issue_cnt) : '0;
    write_data_array = recv_fire;
    fill_address     = recv_fire ? word_addr(base, recv_cnt) : '0;
    fill_data        = recv_fire ? memory_data : '0;
    write_tag_array  = last_word;
    state_dbg        = state;
  end

`ifdef CACHE_FILL_MISS_COUNTER_EN
  // Counts completed fills only; an aborted fill never reaches the tag pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_count <= '0;
    end else if (last_word && (miss_count != '1)) begin
      miss_count <= miss_count + MISS_COUNT_W'(1);
    end
  end
`endif

endmodule : cache_fill_fsm

// File: tb/tb_cache_fill_fsm.sv
// -----------------------------------------------------------------------------
// tb_cache_fill_fsm
//   Self-checking bench for cache_fill_fsm. A behavioural memory (request
//   queue with fixed latency and random return gaps) drives the DUT; each
//   test task builds the expected request/write streams from the block rules
//   (block base = address rounded down to 16 bytes, word k at base + 2k) and
//   compares them with what was observed.
// -----------------------------------------------------------------------------
module tb_cache_fill_fsm;
  import cache_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic [DATA_W-1:0] memory_data;
  logic              memory_data_valid;
  logic              fsm_busy;
  logic              mem_read_en;
  logic [ADDR_W-1:0] memory_address;
  logic              write_data_array;
  logic [ADDR_W-1:0] fill_address;
  logic [DATA_W-1:0] fill_data;
  logic              write_tag_array;
  fill_state_t       state_dbg;
`ifdef CACHE_FILL_MISS_COUNTER_EN
  logic [15:0]       miss_count;
`endif

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .fill_address      (fill_address),
    .fill_data         (fill_data),
    .write_tag_array   (write_tag_array),
`ifdef CACHE_FILL_MISS_COUNTER_EN
    .miss_count        (miss_count),
`endif
    .state_dbg         (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- observation logs filled by the driver ----------------
  logic [ADDR_W-1:0] req_addr_q[$];
  int                req_cyc_q[$];
  logic [31:0]       wr_q[$];      // {fill_address, fill_data}
  int                wr_cyc_q[$];
  int                tag_cyc_q[$];
  logic [DATA_W-1:0] sent_q[$];    // words the memory model returned in FILL
  logic              busy_log[$];  // fsm_busy per cycle, index = cycle
  int                due_q[$];     // memory model: cycle each request returns
  int post_wr, post_tag, post_req, post_busy, post_state;

  // scoreboard
  logic [31:0]       exp_q[$];

  localparam int MAX_CYC = 200;

  task automatic apply_reset();
    rst = 1'b1; miss_detected = 1'b0; memory_data_valid = 1'b0;
    miss_address = '0; memory_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drives one miss (cycle 0) and services memory until the tag pulse, a
  // reset abort after 'abort_after' written words, or the cycle budget.
  // Returns at posedge+1 of the cycle following the last observed one.
  task automatic drive_fill(input logic [ADDR_W-1:0] a, input int lat, input int gap_pct,
                            input bit hold_miss, input logic [ADDR_W-1:0] other,
                            input int abort_after);
    int  nwr;
    bit  done;
    bit  aborted;
    int  c;
    req_addr_q.delete(); req_cyc_q.delete(); wr_q.delete(); wr_cyc_q.delete();
    tag_cyc_q.delete(); sent_q.delete(); busy_log.delete(); due_q.delete();
    post_wr = 0; post_tag = 0; post_req = 0; post_busy = 0; post_state = 0;
    nwr = 0; done = 1'b0; aborted = 1'b0;
    miss_detected = 1'b1; miss_address = a; memory_data_valid = 1'b0;
    memory_data = DATA_W'($urandom);
    @(negedge clk);
    busy_log.push_back(fsm_busy);
    if (mem_read_en) begin req_addr_q.push_back(memory_address); req_cyc_q.push_back(0); end
    @(posedge clk); #1;
    c = 1;
    while (!done && c < MAX_CYC) begin
      miss_detected = hold_miss;
      miss_address  = hold_miss ? other : ADDR_W'($urandom);
      rst = (abort_after >= 0) && (nwr == abort_after);
      memory_data = DATA_W'($urandom);
      memory_data_valid = 1'b0;
      if (!rst && due_q.size() > 0 && due_q[0] <= c && $urandom_range(0, 99) >= gap_pct) begin
        memory_data_valid = 1'b1;
        sent_q.push_back(memory_data);
        void'(due_q.pop_front());
      end
      @(negedge clk);
      busy_log.push_back(fsm_busy);
      if (rst) begin
        aborted = 1'b1; done = 1'b1;
      end else begin
        if (mem_read_en) begin
          req_addr_q.push_back(memory_address); req_cyc_q.push_back(c); due_q.push_back(c + lat);
        end
        if (write_data_array) begin
          wr_q.push_back({fill_address, fill_data}); wr_cyc_q.push_back(c); nwr++;
        end
        if (write_tag_array) begin
          tag_cyc_q.push_back(c); done = 1'b1;
        end
      end
      @(posedge clk); #1;
      c++;
    end
    if (aborted) begin
      // Memory keeps returning the words still in flight; all must be ignored.
      rst = 1'b0; miss_detected = 1'b0;
      for (int k = 0; k < 16; k++) begin
        memory_data = DATA_W'($urandom);
        memory_data_valid = 1'b0;
        if (due_q.size() > 0 && due_q[0] <= c) begin
          memory_data_valid = 1'b1; void'(due_q.pop_front());
        end
        @(negedge clk);
        if (write_data_array) post_wr++;
        if (write_tag_array)  post_tag++;
        if (mem_read_en)      post_req++;
        if (fsm_busy)         post_busy++;
        if (state_dbg != IDLE) post_state++;
        @(posedge clk); #1;
        c++;
      end
    end
    memory_data_valid = 1'b0;
  endtask

  // Reference: word k of the block holding address a lands at base + 2k.
  function automatic logic [ADDR_W-1:0] model_base(input logic [ADDR_W-1:0] a);
    return a - (a % 16);
  endfunction

  task automatic build_expected(input logic [ADDR_W-1:0] base);
    exp_q.delete();
    for (int k = 0; k < sent_q.size(); k++)
      exp_q.push_back({16'(base + 2 * k), sent_q[k]});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; miss_detected = 1'b1; miss_address = 16'h1234;
    memory_data_valid = 1'b1; memory_data = 16'hBEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", state_dbg); end
    checks++; if ({fsm_busy, mem_read_en, write_data_array, write_tag_array} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes got %b want 0000", {fsm_busy, mem_read_en, write_data_array, write_tag_array}); end
    checks++; if (memory_address !== 16'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", memory_address); end
    checks++; if (fill_address !== 16'h0) begin errors++; $display("FAIL reset_fill_addr got %h want 0", fill_address); end
    checks++; if (fill_data !== 16'h0) begin errors++; $display("FAIL reset_fill_data got %h want 0", fill_data); end
`ifdef CACHE_FILL_MISS_COUNTER_EN
    checks++; if (miss_count !== 16'h0) begin errors++; $display("FAIL reset_miss_count got %0d want 0", miss_count); end
`endif
    // valid data while idle must be ignored
    @(posedge clk); #1;
    rst = 1'b0; miss_detected = 1'b0; memory_data_valid = 1'b1;
    @(negedge clk);
    checks++; if ({write_data_array, write_tag_array, fsm_busy} !== 3'b0) begin
      errors++; $display("FAIL idle_valid_ignored got %b want 000", {write_data_array, write_tag_array, fsm_busy}); end
    @(posedge clk); #1;
    memory_data_valid = 1'b0;
  endtask

  task automatic test_basic_fill();
    logic [ADDR_W-1:0] base;
    int bad_busy;
    base = 16'h1230;
    drive_fill(16'h1234, 4, 0, 1'b0, 16'h0, -1);
    build_expected(base);
    checks++; if (req_addr_q.size() != 8) begin errors++; $display("FAIL basic_req_count got %0d want 8", req_addr_q.size()); end
    for (int i = 0; i < req_addr_q.size(); i++) begin
      checks++;
      if (req_addr_q[i] !== 16'(base + 2 * i) || req_cyc_q[i] != i + 1) begin
        errors++; $display("FAIL basic_req[%0d] got %h@%0d want %h@%0d", i, req_addr_q[i], req_cyc_q[i], 16'(base + 2 * i), i + 1); end
    end
    checks++; if (wr_q.size() != 8) begin errors++; $display("FAIL basic_wr_count got %0d want 8", wr_q.size()); end
    for (int k = 0; k < wr_q.size(); k++) begin
      checks++;
      if (exp_q.size() == 0 || wr_q[k] !== exp_q[0]) begin
        errors++; $display("FAIL basic_wr[%0d] got %h want %h", k, wr_q[k], exp_q.size() ? exp_q[0] : 32'hx); end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    checks++;
    if (tag_cyc_q.size() != 1 || tag_cyc_q[0] != 12 || wr_cyc_q.size() != 8 || wr_cyc_q[7] != tag_cyc_q[0]) begin
      errors++; $display("FAIL basic_tag got %0d pulses first@%0d want 1@12", tag_cyc_q.size(), tag_cyc_q.size() ? tag_cyc_q[0] : -1); end
    bad_busy = (busy_log[0] !== 1'b0) ? 1 : 0;
    for (int c = 1; c < busy_log.size(); c++) if (busy_log[c] !== 1'b1) bad_busy++;
    checks++; if (bad_busy != 0) begin errors++; $display("FAIL basic_busy got %0d bad cycles want 0", bad_busy); end
    miss_detected = 1'b0;
    @(negedge clk);
    checks++; if (fsm_busy !== 1'b0 || state_dbg !== IDLE) begin
      errors++; $display("FAIL basic_busy_drop got busy=%b state=%0d want 0/IDLE", fsm_busy, state_dbg); end
    @(posedge clk); #1;
  endtask

  task automatic test_gapped_return();
    logic [ADDR_W-1:0] a;
    int lat;
    for (int it = 0; it < 4; it++) begin
      a = ADDR_W'($urandom); lat = $urandom_range(1, 6);
      drive_fill(a, lat, 50, 1'b0, 16'h0, -1);
      build_expected(model_base(a));
      checks++; if (wr_q.size() != 8 || sent_q.size() != 8) begin
        errors++; $display("FAIL gap_wr_count got %0d writes/%0d valid want 8/8", wr_q.size(), sent_q.size()); end
      for (int k = 0; k < wr_q.size(); k++) begin
        checks++;
        if (exp_q.size() == 0 || wr_q[k] !== exp_q[0]) begin
          errors++; $display("FAIL gap_wr[%0d] got %h want %h", k, wr_q[k], exp_q.size() ? exp_q[0] : 32'hx); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      checks++; if (tag_cyc_q.size() != 1 || wr_cyc_q.size() != 8 || tag_cyc_q[0] != wr_cyc_q[7]) begin
        errors++; $display("FAIL gap_tag got %0d pulses want 1 on 8th valid word", tag_cyc_q.size()); end
      miss_detected = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_busy_miss();
    logic [ADDR_W-1:0] bases[2];
    bases[0] = 16'h0040; bases[1] = 16'hFFF0;
    for (int f = 0; f < 2; f++) begin
      // first fill keeps miss_detected high with a different address; the
      // second fill is the re-raised miss picked up straight after it
      if (f == 0) drive_fill(16'h0040, 3, 20, 1'b1, 16'hFFF6, -1);
      else        drive_fill(16'hFFF6, 2, 0, 1'b0, 16'h0, -1);
      build_expected(bases[f]);
      checks++; if (busy_log[0] !== 1'b0) begin errors++; $display("FAIL busy_miss_start[%0d] got busy=1 at miss want 0", f); end
      checks++; if (req_addr_q.size() != 8) begin errors++; $display("FAIL busy_miss_req_count[%0d] got %0d want 8", f, req_addr_q.size()); end
      for (int i = 0; i < req_addr_q.size(); i++) begin
        checks++; if (req_addr_q[i] !== 16'(bases[f] + 2 * i)) begin
          errors++; $display("FAIL busy_miss_req[%0d][%0d] got %h want %h", f, i, req_addr_q[i], 16'(bases[f] + 2 * i)); end
      end
      checks++; if (wr_q.size() != 8) begin errors++; $display("FAIL busy_miss_wr_count[%0d] got %0d want 8", f, wr_q.size()); end
      for (int k = 0; k < wr_q.size(); k++) begin
        checks++;
        if (exp_q.size() == 0 || wr_q[k] !== exp_q[0]) begin
          errors++; $display("FAIL busy_miss_wr[%0d][%0d] got %h want %h", f, k, wr_q[k], exp_q.size() ? exp_q[0] : 32'hx); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
    end
    miss_detected = 1'b0;
    @(negedge clk);
    checks++; if (fsm_busy !== 1'b0) begin errors++; $display("FAIL busy_miss_end got busy=%b want 0", fsm_busy); end
    @(posedge clk); #1;
  endtask

`ifdef CACHE_FILL_MISS_COUNTER_EN
  task automatic test_miss_counter();
    apply_reset();
    for (int f = 0; f < 3; f++) begin
      drive_fill(ADDR_W'($urandom), $urandom_range(1, 4), 30, 1'b0, 16'h0, -1);
      miss_detected = 1'b0;
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++; if (miss_count !== 16'd3) begin errors++; $display("FAIL miss_count got %0d want 3", miss_count); end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_reset_mid_fill();
    logic [ADDR_W-1:0] a;
    a = ADDR_W'($urandom);
    drive_fill(a, 2, 0, 1'b0, 16'h0, 3);
    checks++; if (wr_q.size() != 3) begin errors++; $display("FAIL abort_pre_writes got %0d want 3", wr_q.size()); end
    checks++; if (tag_cyc_q.size() != 0 || post_tag != 0) begin
      errors++; $display("FAIL abort_tag got %0d pulses want 0", tag_cyc_q.size() + post_tag); end
    checks++; if (post_wr != 0) begin errors++; $display("FAIL abort_late_writes got %0d want 0", post_wr); end
    checks++; if (post_req != 0 || post_busy != 0 || post_state != 0) begin
      errors++; $display("FAIL abort_idle got req=%0d busy=%0d notidle=%0d want 0/0/0", post_req, post_busy, post_state); end
`ifdef CACHE_FILL_MISS_COUNTER_EN
    @(negedge clk);
    checks++; if (miss_count !== 16'd0) begin errors++; $display("FAIL abort_miss_count got %0d want 0", miss_count); end
    @(posedge clk); #1;
`endif
    // a fresh fill after the abort starts cleanly from word 0
    a = ADDR_W'($urandom);
    drive_fill(a, 3, 25, 1'b0, 16'h0, -1);
    build_expected(model_base(a));
    checks++; if (wr_q.size() != 8 || tag_cyc_q.size() != 1) begin
      errors++; $display("FAIL abort_recover got %0d writes %0d pulses want 8/1", wr_q.size(), tag_cyc_q.size()); end
    for (int k = 0; k < wr_q.size(); k++) begin
      checks++;
      if (exp_q.size() == 0 || wr_q[k] !== exp_q[0]) begin
        errors++; $display("FAIL abort_recover_wr[%0d] got %h want %h", k, wr_q[k], exp_q.size() ? exp_q[0] : 32'hx); end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    miss_detected = 1'b0;
`ifdef CACHE_FILL_MISS_COUNTER_EN
    @(negedge clk);
    checks++; if (miss_count !== 16'd1) begin errors++; $display("FAIL recover_miss_count got %0d want 1", miss_count); end
`endif
    @(posedge clk); #1;
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst = 1'b1; miss_detected = 1'b0; miss_address = '0;
    memory_data = '0; memory_data_valid = 1'b0;
    test_reset();
    test_basic_fill();
    test_gapped_return();
    test_busy_miss();
`ifdef CACHE_FILL_MISS_COUNTER_EN
    test_miss_counter();
`endif
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cache_fill_fsm
